// File: rtl/icache_direct_mapped_if.sv
// Purpose: core-side and memory-side bus of the direct-mapped instruction cache.
//   proc_* : core request (read/write/addr/wdata) and response (stall/rdata)
//   mem_*  : line fill request (read/write/addr/wdata) and response (rdata/ready)
// Modports: slave = the cache, master = the core and memory side that drives it.
interface icache_direct_mapped_if;
    localparam int unsigned ADDR_W  = 30;
    localparam int unsigned LADDR_W = 28;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LINE_W  = 128;

    logic                 proc_read;
    logic                 proc_write;
    logic [ADDR_W-1:0]    proc_addr;
    logic [WORD_W-1:0]    proc_wdata;
    logic                 proc_stall;
    logic [WORD_W-1:0]    proc_rdata;

    logic                 mem_read;
    logic                 mem_write;
    logic [LADDR_W-1:0]   mem_addr;
    logic [LINE_W-1:0]    mem_wdata;
    logic [LINE_W-1:0]    mem_rdata;
    logic                 mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_stall, proc_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_stall, proc_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Purpose: read-only direct-mapped instruction cache, 2**IDX_W lines of 4 words.
//   Hits return the word combinationally with no stall; a miss stalls the core,
//   fetches the whole line from memory and re-looks it up once the fill lands.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous reset, active HIGH despite the name (kept for the core's port map)
//   bus    - icache_direct_mapped_if.slave: proc_* core port, mem_* fill port
//   stat_hit / stat_miss (32b) - hit and miss counters, only with ICACHE_STATS_EN defined
// Build option: ICACHE_STATS_EN adds the statistics counters and their ports.
module icache_direct_mapped #(
    parameter int unsigned IDX_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    icache_direct_mapped_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]            stat_hit,
    output logic [31:0]            stat_miss
`endif
);
    localparam int unsigned LINES   = 2 ** IDX_W;
    localparam int unsigned TAG_W   = 30 - 2 - IDX_W;
    localparam int unsigned LADDR_W = 28;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LINE_W  = 128;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [LADDR_W-1:0]   miss_addr_q, miss_addr_d;
    logic                 mem_read_q, mem_read_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]     tag_arr_q  [LINES];
    logic [LINE_W-1:0]    data_arr_q [LINES];

    logic [IDX_W-1:0]     idx_c;
    logic [TAG_W-1:0]     tag_c;
    logic [1:0]           off_c;
    logic [IDX_W-1:0]     miss_idx_c;
    logic [TAG_W-1:0]     miss_tag_c;
    logic                 hit_c;
    logic                 fill_c;
    logic                 start_miss_c;

    // Write data and proc_write are never consumed by a read-only cache.
    logic unused_c;
    assign unused_c = ^{bus.proc_write, bus.proc_wdata};

    // Address split and lookup.
    assign off_c      = bus.proc_addr[1:0];
    assign idx_c      = bus.proc_addr[IDX_W+1:2];
    assign tag_c      = bus.proc_addr[29:IDX_W+2];
    assign miss_idx_c = miss_addr_q[IDX_W-1:0];
    assign miss_tag_c = miss_addr_q[LADDR_W-1:IDX_W];
    assign hit_c      = bus.proc_read & valid_q[idx_c] & (tag_arr_q[idx_c] == tag_c);

    // Response to the core; rdata forced to zero whenever there is no hit.
    assign bus.proc_rdata = hit_c ? data_arr_q[idx_c][{off_c, 5'b0} +: WORD_W] : WORD_W'(0);
    assign bus.proc_stall = (state_q == S_FETCH) |
                            ((state_q == S_IDLE) & bus.proc_read & ~hit_c);

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_addr  = miss_addr_q;
    assign bus.mem_write = 1'b0;
    assign bus.mem_wdata = LINE_W'(0);

    // Next-state logic; the latched miss address is the only fill target, so a
    // redirected core cannot retarget a fill already in flight.
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        mem_read_d   = mem_read_q;
        valid_d      = valid_q;
        fill_c       = 1'b0;
        start_miss_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.proc_read && !hit_c) begin
                    state_d      = S_FETCH;
                    miss_addr_d  = bus.proc_addr[29:2];
                    mem_read_d   = 1'b1;
                    start_miss_c = 1'b1;
                end
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d             = S_IDLE;
                    mem_read_d          = 1'b0;
                    fill_c              = 1'b1;
                    valid_d[miss_idx_c] = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    // Control state; reset clears valid bits but leaves tag/data storage alone.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            miss_addr_q <= LADDR_W'(0);
            mem_read_q  <= 1'b0;
            valid_q     <= LINES'(0);
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            mem_read_q  <= mem_read_d;
            valid_q     <= valid_d;
        end
    end

    // Line storage, written only by a completing fill.
    always_ff @(posedge clk) begin
        if (fill_c) begin
            tag_arr_q[miss_idx_c]  <= miss_tag_c;
            data_arr_q[miss_idx_c] <= bus.mem_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hit_q, stat_hit_d;
    logic [31:0] stat_miss_q, stat_miss_d;

    // Hits are counted per IDLE cycle, misses per fill started; both wrap.
    always_comb begin
        stat_hit_d  = stat_hit_q;
        stat_miss_d = stat_miss_q;
        if ((state_q == S_IDLE) && hit_c) begin
            stat_hit_d = stat_hit_q + 32'd1;
        end
        if (start_miss_c) begin
            stat_miss_d = stat_miss_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            stat_hit_q  <= 32'd0;
            stat_miss_q <= 32'd0;
        end else begin
            stat_hit_q  <= stat_hit_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_hit  = stat_hit_q;
    assign stat_miss = stat_miss_q;
`else
    logic unused_start_c;
    assign unused_start_c = start_miss_c;
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Purpose: directed bench for icache_direct_mapped: fills, hit vectors, conflict,
// redirect during fill, stray mem_ready, reset mid-fill and optional counters.
module tb_icache_direct_mapped;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icache_direct_mapped_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hit;
    logic [31:0] stat_miss;
`endif

    icache_direct_mapped dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hit  (stat_hit),
        .stat_miss (stat_miss)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic        exp_stall;
        logic [31:0] exp_rdata;
        logic        exp_mem_read;
    } vec_t;

    vec_t vecs [6];

    // Memory image: every word is unique per line address and offset.
    function automatic logic [31:0] mem_word(logic [27:0] la, logic [1:0] k);
        return {4'hA, la[23:0], 2'b00, k};
    endfunction

    function automatic logic [127:0] mem_line(logic [27:0] la);
        return {mem_word(la, 2'd3), mem_word(la, 2'd2), mem_word(la, 2'd1), mem_word(la, 2'd0)};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge.
    task automatic cyc(logic rd, logic wr, logic [29:0] addr, logic rdy, logic [127:0] line);
        @(posedge clk);
        #1;
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = addr;
        bus.mem_ready  = rdy;
        bus.mem_rdata  = rdy ? line : 128'd0;
        @(negedge clk);
    endtask

    // Full miss: detect cycle, n memory cycles (ready in the last), re-lookup hit.
    task automatic do_miss(logic [29:0] addr, int n);
        logic [27:0] la;
        la = addr[29:2];
        cyc(1'b1, 1'b0, addr, 1'b0, 128'd0);
        check("miss_detect_stall", 128'(bus.proc_stall), 128'(1'b1));
        check("miss_detect_mem_read", 128'(bus.mem_read), 128'(1'b0));
        check("miss_detect_rdata", 128'(bus.proc_rdata), 128'd0);
        for (int i = 1; i <= n; i++) begin
            cyc(1'b1, 1'b0, addr, (i == n), mem_line(la));
            check("fetch_stall", 128'(bus.proc_stall), 128'(1'b1));
            check("fetch_mem_read", 128'(bus.mem_read), 128'(1'b1));
            check("fetch_mem_addr", 128'(bus.mem_addr), 128'(la));
        end
        cyc(1'b1, 1'b0, addr, 1'b0, 128'd0);
        check("refill_stall", 128'(bus.proc_stall), 128'(1'b0));
        check("refill_mem_read", 128'(bus.mem_read), 128'(1'b0));
        check("refill_rdata", 128'(bus.proc_rdata), 128'(mem_word(la, addr[1:0])));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 30'h1,   1'b0, mem_word(28'h0, 2'd1), 1'b0};
        vecs[1] = '{1'b1, 1'b0, 30'h2,   1'b0, mem_word(28'h0, 2'd2), 1'b0};
        vecs[2] = '{1'b1, 1'b0, 30'h3,   1'b0, mem_word(28'h0, 2'd3), 1'b0};
        vecs[3] = '{1'b1, 1'b0, 30'h0,   1'b0, mem_word(28'h0, 2'd0), 1'b0};
        vecs[4] = '{1'b0, 1'b1, 30'h3ff, 1'b0, 32'd0,                 1'b0};
        vecs[5] = '{1'b0, 1'b0, 30'h2,   1'b0, 32'd0,                 1'b0};

        rst_n          = 1'b1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = 30'd0;
        bus.proc_wdata = 32'hDEAD_BEEF;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 128'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_stall", 128'(bus.proc_stall), 128'd0);
        check("rst_rdata", 128'(bus.proc_rdata), 128'd0);
        check("rst_mem_read", 128'(bus.mem_read), 128'd0);
        check("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
        check("rst_mem_write", 128'(bus.mem_write), 128'd0);
        check("rst_mem_wdata", bus.mem_wdata, 128'd0);

        // First fill of line 0, four memory cycles.
        do_miss(30'h0, 4);

        for (int i = 0; i < 6; i++) begin
            cyc(vecs[i].rd, vecs[i].wr, vecs[i].addr, 1'b0, 128'd0);
            check($sformatf("tbl_stall[%0d]", i), 128'(bus.proc_stall), 128'(vecs[i].exp_stall));
            check($sformatf("tbl_rdata[%0d]", i), 128'(bus.proc_rdata), 128'(vecs[i].exp_rdata));
            check($sformatf("tbl_mem_read[%0d]", i), 128'(bus.mem_read), 128'(vecs[i].exp_mem_read));
        end

        // Conflict on index 0: tag 1 evicts tag 0, which then misses again.
        do_miss(30'h20, 2);
        do_miss(30'h0, 1);

        // Redirect: core drops the request, fill to line address 4 still completes.
        cyc(1'b1, 1'b0, 30'h10, 1'b0, 128'd0);
        check("redir_detect_stall", 128'(bus.proc_stall), 128'(1'b1));
        cyc(1'b0, 1'b0, 30'h10, 1'b0, 128'd0);
        check("redir_mem_read0", 128'(bus.mem_read), 128'(1'b1));
        check("redir_mem_addr0", 128'(bus.mem_addr), 128'h4);
        check("redir_stall0", 128'(bus.proc_stall), 128'(1'b1));
        cyc(1'b0, 1'b0, 30'h3ff, 1'b0, 128'd0);
        check("redir_mem_read1", 128'(bus.mem_read), 128'(1'b1));
        check("redir_mem_addr1", 128'(bus.mem_addr), 128'h4);
        cyc(1'b0, 1'b0, 30'h3ff, 1'b1, mem_line(28'h4));
        check("redir_mem_read2", 128'(bus.mem_read), 128'(1'b1));
        cyc(1'b0, 1'b0, 30'h3ff, 1'b0, 128'd0);
        check("redir_done_mem_read", 128'(bus.mem_read), 128'd0);
        check("redir_done_stall", 128'(bus.proc_stall), 128'd0);
        cyc(1'b1, 1'b0, 30'h10, 1'b0, 128'd0);
        check("redir_hit_stall", 128'(bus.proc_stall), 128'd0);
        check("redir_hit_rdata", 128'(bus.proc_rdata), 128'(mem_word(28'h4, 2'd0)));

        // Stray mem_ready in IDLE must not write anything.
        cyc(1'b0, 1'b0, 30'h0, 1'b1, {4{32'hFFFF_FFFF}});
        check("stray_mem_read", 128'(bus.mem_read), 128'd0);
        cyc(1'b1, 1'b0, 30'h12, 1'b0, 128'd0);
        check("stray_stall", 128'(bus.proc_stall), 128'd0);
        check("stray_rdata", 128'(bus.proc_rdata), 128'(mem_word(28'h4, 2'd2)));

        // Reset in the middle of a fill.
        cyc(1'b1, 1'b0, 30'h40, 1'b0, 128'd0);
        cyc(1'b1, 1'b0, 30'h40, 1'b0, 128'd0);
        check("rstf_mem_read", 128'(bus.mem_read), 128'(1'b1));
        check("rstf_mem_addr", 128'(bus.mem_addr), 128'h10);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.proc_read = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rstf_after_mem_read", 128'(bus.mem_read), 128'd0);
        check("rstf_after_mem_addr", 128'(bus.mem_addr), 128'd0);
        check("rstf_after_stall", 128'(bus.proc_stall), 128'd0);
        cyc(1'b0, 1'b0, 30'h0, 1'b1, mem_line(28'h10));
        check("rstf_late_ready_mem_read", 128'(bus.mem_read), 128'd0);
        do_miss(30'h10, 3);
        do_miss(30'h0, 1);

`ifdef ICACHE_STATS_EN
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.proc_read = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("stat_hit_rst", 128'(stat_hit), 128'd0);
        check("stat_miss_rst", 128'(stat_miss), 128'd0);
        // Each do_miss ends with one hit cycle: 3 misses + 3 hits, then 6 more hits.
        do_miss(30'h0, 2);
        do_miss(30'h24, 1);
        do_miss(30'h48, 3);
        cyc(1'b1, 1'b0, 30'h1, 1'b0, 128'd0);
        cyc(1'b1, 1'b0, 30'h2, 1'b0, 128'd0);
        cyc(1'b1, 1'b0, 30'h3, 1'b0, 128'd0);
        cyc(1'b1, 1'b0, 30'h25, 1'b0, 128'd0);
        cyc(1'b1, 1'b0, 30'h26, 1'b0, 128'd0);
        cyc(1'b1, 1'b0, 30'h49, 1'b0, 128'd0);
        check("stat_last_hit_stall", 128'(bus.proc_stall), 128'd0);
        cyc(1'b0, 1'b1, 30'h3ff, 1'b0, 128'd0);
        check("stat_write_stall", 128'(bus.proc_stall), 128'd0);
        cyc(1'b0, 1'b1, 30'h3ff, 1'b0, 128'd0);
        check("stat_hit_final", 128'(stat_hit), 128'd9);
        check("stat_miss_final", 128'(stat_miss), 128'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
